// File: rtl/sigmoid_activation_ctrl.sv
// -----------------------------------------------------------------------------
// sigmoid_activation_ctrl
//
// Pipelined front/back end for the half-range sigmoid lookup ROM. It sits
// between the neuron accumulator (upstream) and the layer output buffer
// (downstream).
//
//   S1: fold the signed Q8.8 sample onto x >= 0, quantise it to the ROM step
//       of 0.1 (round to nearest), clamp to MAX_IDX and register the ROM
//       address together with the sign and saturation flags.
//   S2: capture the ROM word and reflect it for negative inputs using
//       sigma(-x) = 1 - sigma(x).
//
// Both stages advance together whenever the output register is empty or is
// being drained, so a stalled output freezes the whole pipeline and no sample
// is lost or duplicated. Latency is 2 cycles, throughput 1 sample per cycle.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      input sample valid
//   in_ready   out  1      block can accept a sample this cycle
//   in_x       in   IN_W   signed Q8.8 pre-activation
//   rom_addr   out  7      registered ROM index, 0..MAX_IDX
//   rom_data   in   16     combinational ROM word, bits [7:0] used
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   out_y      out  OUT_W  sigmoid(in_x), unsigned Q0.8
//   out_sat    out  1      |in_x| quantised above MAX_IDX, index clamped
//   sample_cnt out  CNT_W  results accepted downstream (wraps)
// -----------------------------------------------------------------------------
module sigmoid_activation_ctrl #(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 8,
    parameter int MAX_IDX = 60,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_x,
    output logic [6:0]       rom_addr,
    input  logic [15:0]      rom_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_y,
    output logic             out_sat,
    output logic [CNT_W-1:0] sample_cnt
);

    // Magnitude needs one extra bit so that the most negative input folds
    // to a representable positive value (-32768 -> 32768).
    localparam int AX_W  = IN_W + 1;
    // ax * 10 + 128 needs 4 more bits than ax; no overflow is possible.
    localparam int SC_W  = AX_W + 4;
    // Index width after dropping the 8 fractional bits.
    localparam int IDX_W = SC_W - 8;

    // -------------------------------------------------------------------------
    // Pipeline control
    // -------------------------------------------------------------------------
    logic advance;

    // The whole pipeline moves when the output slot is free or being emptied.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // -------------------------------------------------------------------------
    // S1 combinational front end: fold, quantise, clamp
    // -------------------------------------------------------------------------
    logic             neg;
    logic [AX_W-1:0]  ax;
    logic [SC_W-1:0]  scaled;
    logic [IDX_W-1:0] raw_idx;
    logic [6:0]       idx;
    logic             sat;

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        neg     = in_x[IN_W-1];
        ax      = {1'b0, in_x};
        idx     = '0;
        sat     = 1'b0;

        if (neg) begin
            ax = AX_W'(0) - {in_x[IN_W-1], in_x};
        end

        // Round |x| / 0.1 to nearest: (ax * 10 + 0.5 LSB of index) >> 8.
        scaled  = (SC_W'(ax) * SC_W'(10)) + SC_W'(128);
        raw_idx = IDX_W'(scaled >> 8);

        if (raw_idx > IDX_W'(MAX_IDX)) begin
            idx = 7'(MAX_IDX);
            sat = 1'b1;
        end else begin
            idx = raw_idx[6:0];
        end
    end

    // -------------------------------------------------------------------------
    // S1 registers
    // -------------------------------------------------------------------------
    logic s1_valid;
    logic s1_neg;
    logic s1_sat;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge value of its inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_neg   <= 1'b0;
            s1_sat   <= 1'b0;
            rom_addr <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            // Data only moves with a real sample; bubbles leave stale data
            // behind a cleared valid.
            if (in_valid) begin
                s1_neg   <= neg;
                s1_sat   <= sat;
                rom_addr <= idx;
            end
        end
    end

    // -------------------------------------------------------------------------
    // S2 combinational back end: reflect for negative inputs
    // -------------------------------------------------------------------------
    logic [OUT_W-1:0] rom_word;
    logic [OUT_W-1:0] y_next;
    logic [7:0]       rom_hi_unused;

    // The upper ROM byte carries nothing for this block.
    assign rom_hi_unused = rom_data[15:8];
    assign rom_word      = rom_data[OUT_W-1:0];

    // The ROM only stores sigma(x) for x >= 0, so its words are >= 0x80 and
    // 256 - d never wraps below zero.
    assign y_next = s1_neg ? OUT_W'(9'd256 - {1'b0, rom_word}) : rom_word;

    // -------------------------------------------------------------------------
    // S2 registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_y     <= '0;
            out_sat   <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_y   <= y_next;
                out_sat <= s1_sat;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Accepted-result counter (wraps naturally at 2^CNT_W)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
        end else if (out_valid && out_ready) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sigmoid_activation_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sigmoid_activation_ctrl
//
// Self-checking bench for sigmoid_activation_ctrl. The bench provides the
// half-range sigmoid ROM (round(256*sigma(k/10)), saturated at 0xFF) and a
// scoreboard: an expected result is queued for every input transfer and
// compared when the matching output transfer happens.
// -----------------------------------------------------------------------------
module tb_sigmoid_activation_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [6:0]  rom_addr;
    logic [15:0] rom_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_y;
    logic        out_sat;
    logic [15:0] sample_cnt;

    typedef struct packed {
        logic [7:0] y;
        logic       sat;
    } exp_t;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] y;
        logic       sat;
    } model_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt;
    logic        prev_in_xfer;
    logic [6:0]  prev_addr;
    int          in_since_rst;

    sigmoid_activation_ctrl #(
        .IN_W   (16),
        .OUT_W  (8),
        .MAX_IDX(60),
        .CNT_W  (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_sat   (out_sat),
        .sample_cnt(sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contract: round(256 * sigma(k/10)), saturated at 0xFF.
    function automatic logic [7:0] rom_val(input int k);
        real s;
        int  r;
        s = 256.0 / (1.0 + $exp(-(k / 10.0)));
        r = $rtoi(s + 0.5);
        if (r > 255) r = 255;
        return 8'(r);
    endfunction

    // Upper byte is junk; the DUT must only use bits [7:0].
    always_comb rom_data = {8'hA5, rom_val(int'(rom_addr))};

    // Reference model of one sample, written in plain integer arithmetic.
    function automatic model_t model(input logic [15:0] x);
        int         v;
        int         a;
        int         i;
        logic [7:0] d;
        model_t     m;
        v     = int'($signed(x));
        a     = (v < 0) ? -v : v;
        i     = (a * 10 + 128) / 256;
        m.sat = (i > 60);
        if (i > 60) i = 60;
        m.addr = 7'(i);
        d      = rom_val(i);
        m.y    = (v < 0) ? 8'(256 - int'(d)) : d;
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: observe at the falling edge, then step past the rising
    // edge. Inputs are driven by the caller between cycles.
    task automatic cycle();
        exp_t   e;
        model_t m;
        @(negedge clk);
        check("sample_cnt", 32'(sample_cnt), 32'(exp_cnt));
        check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
        if (prev_in_xfer) check("rom_addr", 32'(rom_addr), 32'(prev_addr));
        if (out_valid === 1'b1 && out_ready) begin
            check("out_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_y", 32'(out_y), 32'(e.y));
                check("out_sat", 32'(out_sat), 32'(e.sat));
            end
            exp_cnt = exp_cnt + 16'd1;
        end
        prev_in_xfer = 1'b0;
        if (in_valid && in_ready === 1'b1) begin
            m = model(in_x);
            sb.push_back('{y: m.y, sat: m.sat});
            prev_in_xfer = 1'b1;
            prev_addr    = m.addr;
            in_since_rst++;
        end
        @(posedge clk);
        #1;
    endtask

    // Present one sample until it is accepted (bounded).
    task automatic send(input logic [15:0] x);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_x     = x;
        for (int k = 0; k < 20 && !done; k++) begin
            done = (in_ready === 1'b1);
            cycle();
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    // Single sample through an empty pipeline against fixed expectations.
    task automatic directed(input logic [15:0] x, input logic [6:0] addr,
                            input logic [7:0] y, input logic sat);
        send(x);
        check("dir_rom_addr", 32'(rom_addr), 32'(addr));
        check("dir_lat_s1", 32'(out_valid), 32'd0);
        cycle();
        check("dir_valid", 32'(out_valid), 32'd1);
        check("dir_y", 32'(out_y), 32'(y));
        check("dir_sat", 32'(out_sat), 32'(sat));
        cycle();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_x         = '0;
        out_ready    = 1'b1;
        exp_cnt      = '0;
        prev_in_xfer = 1'b0;
        prev_addr    = '0;
        in_since_rst = 0;

        // Reset state
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_y", 32'(out_y), 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_sample_cnt", 32'(sample_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single samples, including both saturation extremes
        directed(16'h0000, 7'd0,  8'h80, 1'b0);
        directed(16'h0100, 7'd10, 8'hBB, 1'b0);
        directed(16'hFF00, 7'd10, 8'h45, 1'b0);
        directed(16'h0019, 7'd1,  8'h86, 1'b0);
        directed(16'h0700, 7'd60, 8'hFF, 1'b1);
        directed(16'h8000, 7'd60, 8'h01, 1'b1);

        // Back-to-back stream, then a 3-cycle stall with a sample waiting
        in_valid = 1'b1;
        in_x = 16'h0100; cycle();
        in_x = 16'hFF00; cycle();
        check("strm_first_valid", 32'(out_valid), 32'd1);
        check("strm_first_y", 32'(out_y), 32'hBB);
        in_x = 16'h0000; cycle();
        check("strm_second_y", 32'(out_y), 32'h45);
        out_ready = 1'b0;
        in_x      = 16'h0700;
        #1;
        check("stall_in_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_y", 32'(out_y), 32'h45);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_s1_addr", 32'(rom_addr), 32'd0);
        end
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (3) cycle();
        check("strm_drained", 32'(sb.size()), 32'd0);

        // Random traffic with random backpressure
        for (int k = 0; k < 300; k++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_x      = ($urandom_range(0, 9) == 0) ? 16'h8000 : 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cycle();
        check("rand_drained", 32'(sb.size()), 32'd0);

        // Asynchronous reset with two samples in flight
        in_valid = 1'b1;
        in_x = 16'h0100; cycle();
        in_x = 16'hFF00; cycle();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_y", 32'(out_y), 32'd0);
        check("mid_rst_out_sat", 32'(out_sat), 32'd0);
        check("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
        check("mid_rst_sample_cnt", 32'(sample_cnt), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        exp_cnt      = '0;
        prev_in_xfer = 1'b0;
        in_since_rst = 0;
        #1 rst_n = 1'b1;
        repeat (4) cycle();
        check("post_rst_no_stale", 32'(out_valid), 32'd0);
        directed(16'h0019, 7'd1, 8'h86, 1'b0);

        // Counter wrap: 2^16 accepted results since reset
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 70000 && in_since_rst < 65536; k++) begin
            in_x = 16'($urandom);
            cycle();
        end
        in_valid = 1'b0;
        repeat (4) cycle();
        check("cnt_wrap", 32'(sample_cnt), 32'd0);
        check("wrap_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
